// File: rtl/writeback_arbiter_pkg.sv
// Shared processor definitions for the writeback arbiter: FSM encoding and
// the exception register/codes written when a multdiv result faults.
package writeback_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_FORCE = 2'd3
  } wb_state_e;

  localparam logic [4:0]  EXC_REG      = 5'd30;
  localparam logic [31:0] EXC_MUL_CODE = 32'd4;
  localparam logic [31:0] EXC_DIV_CODE = 32'd5;

  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV_CODE : EXC_MUL_CODE;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline writeback, multdiv handshake and regfile write port bundle.
interface writeback_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_start;
  logic        md_is_div;
  logic [4:0]  md_reg;
  logic        md_ready;
  logic [31:0] md_data;
  logic        md_exception;
  logic        md_ack;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        pipe_stall;
  logic        md_busy;
  logic [4:0]  md_busy_reg;

  modport slave (
    input  wb_valid, wb_reg, wb_data, md_start, md_is_div, md_reg,
           md_ready, md_data, md_exception,
    output md_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           pipe_stall, md_busy, md_busy_reg
  );

  modport master (
    output wb_valid, wb_reg, wb_data, md_start, md_is_div, md_reg,
           md_ready, md_data, md_exception,
    input  md_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
           pipe_stall, md_busy, md_busy_reg
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Shares the regfile write port between the pipeline and one multdiv unit.
// WB_STARVE_GUARD_EN adds a starvation counter and a forced-write FORCE state.
import writeback_arbiter_pkg::*;

module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clock,
  input logic                 reset,
  writeback_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("writeback_arbiter: STARVE_LIMIT must be within 1..15");
  end

  wb_state_e   r_state, w_state_nxt;
  logic        r_rst_q;
  logic [4:0]  r_reg;
  logic        r_is_div;
  logic [31:0] r_data;
  logic        r_exc;
`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0]  r_cnt, w_cnt_nxt;
`endif

  logic        w_blank, w_accept, w_capture, w_stall, w_ack;
  logic        w_sel_we, w_we, w_busy;
  logic [4:0]  w_sel_reg, w_buf_reg;
  logic [31:0] w_sel_data, w_buf_data;

  // Outputs are silenced during reset and the cycle after it.
  assign w_blank    = reset | r_rst_q;
  assign w_buf_reg  = r_exc ? EXC_REG : r_reg;
  assign w_buf_data = r_exc ? exc_code(r_is_div) : r_data;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_reg   = '0;
    w_sel_data  = '0;
`ifdef WB_STARVE_GUARD_EN
    w_cnt_nxt   = '0;
`endif
    if (!w_blank) begin
      if (bus.wb_valid && r_state != ST_FORCE) begin
        w_sel_we   = 1'b1;
        w_sel_reg  = bus.wb_reg;
        w_sel_data = bus.wb_data;
      end
      if (bus.md_start) begin
        if (r_state == ST_IDLE) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_stall = 1'b1;
        end
      end
      case (r_state)
        ST_RUN: if (bus.md_ready) begin
          w_ack       = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = ST_PEND;
        end
        ST_PEND: if (!bus.wb_valid) begin
          w_sel_we    = 1'b1;
          w_sel_reg   = w_buf_reg;
          w_sel_data  = w_buf_data;
          w_state_nxt = ST_IDLE;
        end
`ifdef WB_STARVE_GUARD_EN
        else begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (w_cnt_nxt == LIM) w_state_nxt = ST_FORCE;
        end
        ST_FORCE: begin
          w_stall     = 1'b1;
          w_sel_we    = 1'b1;
          w_sel_reg   = w_buf_reg;
          w_sel_data  = w_buf_data;
          w_state_nxt = ST_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // r0 is hardwired: a selected write there is dropped, buffered ones just drain.
  assign w_we   = w_sel_we && (w_sel_reg != 5'd0);
  assign w_busy = !w_blank && (r_state != ST_IDLE);

  assign bus.ctrl_writeEnable = w_we;
  assign bus.ctrl_writeReg    = w_we ? w_sel_reg  : 5'd0;
  assign bus.data_writeReg    = w_we ? w_sel_data : 32'd0;
  assign bus.pipe_stall       = w_stall;
  assign bus.md_ack           = w_ack;
  assign bus.md_busy          = w_busy;
  assign bus.md_busy_reg      = w_busy ? r_reg : 5'd0;

  always_ff @(posedge clock) begin
    r_rst_q <= reset;
    if (reset) begin
      r_state  <= ST_IDLE;
      r_reg    <= '0;
      r_is_div <= 1'b0;
      r_data   <= '0;
      r_exc    <= 1'b0;
`ifdef WB_STARVE_GUARD_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_reg    <= bus.md_reg;
        r_is_div <= bus.md_is_div;
      end
      if (w_capture) begin
        r_data <= bus.md_data;
        r_exc  <= bus.md_exception;
      end
`ifdef WB_STARVE_GUARD_EN
      r_cnt <= w_cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive blocked PEND cycles before a forced multdiv write (range 1..15).
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline writeback request
- wb_reg  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- md_start  in  1  multdiv op issue request
- md_is_div  in  1  issued op is a divide (0 = multiply)
- md_reg  in  5  multdiv destination, sampled with md_start
- md_ready  in  1  multdiv result valid
- md_data  in  32  multdiv result
- md_exception  in  1  multdiv overflow or divide-by-zero
- md_ack  out  1  result captured
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile write address
- data_writeReg  out  32  regfile write data
- pipe_stall  out  1  hold the pipeline
- md_busy  out  1  multdiv op outstanding or result buffered
- md_busy_reg  out  5  outstanding multdiv destination, for decode hazard check

Function
REQ-003 SHALL implement FSM states: IDLE (nothing outstanding), RUN (op issued, awaiting md_ready), PEND (result buffered, awaiting the write port), FORCE (forced buffered write).
REQ-004 SHALL accept md_start only in IDLE: latch md_reg and md_is_div, then IDLE->RUN; md_start in any other state SHALL assert pipe_stall the same cycle and leave state and latched values unchanged.
REQ-005 SHALL, in RUN with md_ready=1, assert md_ack the same cycle, capture data/exception into a one-entry buffer, then RUN->PEND; md_ready outside RUN SHALL be ignored (md_ack=0).
REQ-006 SHALL give the pipeline priority: wb_valid=1 drives the write port combinationally in the same cycle (zero latency) in every state except FORCE.
REQ-007 SHALL, in PEND with wb_valid=0, write the buffered result that cycle, then PEND->IDLE; the earliest buffered write is therefore the cycle after capture.
REQ-008 SHALL redirect an excepting result to register 30 with data 32'd4 (multiply) or 32'd5 (divide).
REQ-009 SHALL force ctrl_writeEnable=0 whenever the selected destination is register 0; a buffered result destined for register 0 SHALL drain (PEND->IDLE) without a write.
REQ-010 SHALL drive ctrl_writeReg=0 and data_writeReg=0 whenever ctrl_writeEnable=0.
REQ-011 SHALL hold md_busy=1 in RUN, PEND and FORCE, and md_busy_reg equal to the latched destination (0 in IDLE).
REQ-012 SHALL assert pipe_stall only per REQ-004 or in FORCE.

Reset
REQ-013 SHALL, with reset high at a clock edge, enter IDLE, clear the buffer, the latched destination and the starvation counter, regardless of the in-flight op (the op's result is discarded).
REQ-014 SHALL hold every output at 0 while in reset and in the first cycle after.

Configuration
REQ-015 SHALL, with WB_STARVE_GUARD_EN defined, count PEND cycles with wb_valid=1; on reaching STARVE_LIMIT go PEND->FORCE. In FORCE: pipe_stall=1, write the buffered result (pipeline write blocked), then FORCE->IDLE; the counter clears on leaving PEND.
REQ-016 SHALL, without WB_STARVE_GUARD_EN, omit the counter and FORCE state; PEND waits indefinitely for wb_valid=0.

Structure
REQ-017 SHALL place the state encoding, the exception register number (30) and the exception codes (4, 5) in the shared processor package.
REQ-018 SHALL be a single module; the starvation counter is small enough to stay inline.

Verification
REQ-019 SHALL cover: wb_valid=1, wb_reg=5, wb_data=0x1234, idle -> same cycle write to r5 of 0x1234, pipe_stall=0.
REQ-020 SHALL cover: md_start, md_reg=7; md_ready 3 cycles later with data 42 and wb_valid=0 -> md_ack that cycle, write to r7 of 42 next cycle, md_busy low after it.
REQ-021 SHALL cover: divide with md_exception=1 -> write to r30 of 5; multiply with md_exception=1 -> write to r30 of 4.
REQ-022 SHALL cover: buffered result, wb_valid held 1, macro defined, STARVE_LIMIT=4 -> 4 pipeline writes, then FORCE cycle with pipe_stall=1 and the buffered write; macro undefined -> no stall, write on first wb_valid=0 cycle.
REQ-023 SHALL cover: md_start while md_busy -> pipe_stall=1, md_busy_reg unchanged; md_reg=0 result -> no write and return to IDLE.
REQ-024 SHALL cover: reset asserted in RUN -> next cycle IDLE, all outputs 0, later md_ready ignored.
